// File: rtl/ahb_lite_master_bridge.sv
// AHB-Lite initiator: turns a valid/ready command stream into single NONSEQ word
// transfers with an overlapped address/data pipeline and in-order responses.
module ahb_lite_master_bridge #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_abort,
  output logic              busy,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  // HADDR/HWRITE double as the address-stage address and direction; HWDATA is the data-stage data.
  logic              a_valid;
  logic [DATA_W-1:0] a_wdata;
  logic              d_valid;
  logic              d_write;
  logic              abort_pend;
  logic              abort_write;

  logic first_error_cycle;
  logic accept;
  logic error_cancel;
  logic data_done;
  logic abort_fire;
  logic a_valid_n;
  logic d_valid_n;
  logic abort_pend_n;
  logic rsp_valid_n;

  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;

  assign first_error_cycle = HRESP && !HREADY;
  assign cmd_ready         = HREADY && !abort_pend && !first_error_cycle;
  assign accept            = cmd_valid && cmd_ready;
  assign error_cancel      = first_error_cycle && a_valid;
  assign data_done         = HREADY && d_valid;
  // The abort response waits until the errored transfer's own response has gone out.
  assign abort_fire        = abort_pend && !d_valid;

  always_comb begin
    a_valid_n    = a_valid;
    d_valid_n    = d_valid;
    abort_pend_n = abort_pend;
    rsp_valid_n  = 1'b0;
    if (HREADY) begin
      d_valid_n   = a_valid;
      a_valid_n   = accept;
      rsp_valid_n = d_valid;
    end else if (error_cancel) begin
      a_valid_n    = 1'b0;
      abort_pend_n = 1'b1;
    end
    if (abort_fire) begin
      abort_pend_n = 1'b0;
      rsp_valid_n  = 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_valid     <= 1'b0;
      a_wdata     <= '0;
      d_valid     <= 1'b0;
      d_write     <= 1'b0;
      abort_pend  <= 1'b0;
      abort_write <= 1'b0;
      HADDR       <= '0;
      HWRITE      <= 1'b0;
      HWDATA      <= '0;
      HTRANS      <= TRANS_IDLE;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_abort   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      a_valid    <= a_valid_n;
      d_valid    <= d_valid_n;
      abort_pend <= abort_pend_n;
      HTRANS     <= a_valid_n ? TRANS_NONSEQ : TRANS_IDLE;
      busy       <= a_valid_n || d_valid_n || abort_pend_n || rsp_valid_n;
      rsp_valid  <= rsp_valid_n;

      if (HREADY) begin
        d_write <= HWRITE;
        HWDATA  <= a_wdata;
        if (accept) begin
          HADDR   <= cmd_addr;
          HWRITE  <= cmd_write;
          a_wdata <= cmd_wdata;
        end
      end else if (error_cancel) begin
        abort_write <= HWRITE;
      end

      if (data_done) begin
        rsp_write <= d_write;
        rsp_err   <= HRESP;
        rsp_rdata <= d_write ? '0 : HRDATA;
        rsp_abort <= 1'b0;
      end else if (abort_fire) begin
        rsp_write <= abort_write;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
        rsp_abort <= 1'b1;
      end else begin
        rsp_write <= 1'b0;
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
        rsp_abort <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Bench for ahb_lite_master_bridge: directed protocol scenarios followed by random
// traffic against a memory-backed slave and an in-order transaction-level model.
module tb_ahb_lite_master_bridge;

  logic        HCLK;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [29:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_abort;
  logic        busy;
  logic [29:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        write;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] shadow[16];
  logic [31:0] slave_mem[16];
  logic        dp_valid;
  logic [3:0]  dp_idx;
  logic        dp_write;
  logic        pend;

  ahb_lite_master_bridge dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_abort(rsp_abort), .busy(busy),
    .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic set_cmd(input logic valid, input logic write, input logic [29:0] addr,
                         input logic [31:0] wdata);
    cmd_valid = valid;
    cmd_write = write;
    cmd_addr  = addr;
    cmd_wdata = wdata;
  endtask

  // One random-traffic cycle: check any response, drive command and slave, then advance.
  task automatic random_cycle(input bit allow_new);
    exp_t e;
    int   idx;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rnd_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rnd_rsp_write", {31'd0, rsp_write}, {31'd0, e.write});
        check("rnd_rsp_rdata", rsp_rdata, e.rdata);
        check("rnd_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rnd_rsp_abort", {31'd0, rsp_abort}, 32'd0);
      end
    end
    if (allow_new && !pend && $urandom_range(0, 2) != 0) begin
      idx = $urandom_range(0, 15);
      set_cmd(1'b1, 1'($urandom_range(0, 1)), 30'(idx * 4), $urandom);
      pend = 1'b1;
    end
    cmd_valid = pend;
    HRESP     = 1'b0;
    HREADY    = dp_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
    HRDATA    = (dp_valid && !dp_write) ? slave_mem[dp_idx] : $urandom;
    #1;
    check("rnd_cmd_ready", {31'd0, cmd_ready}, {31'd0, HREADY});
    if (cmd_valid && HREADY) begin
      idx = int'(cmd_addr[5:2]);
      e.write = cmd_write;
      e.rdata = cmd_write ? 32'd0 : shadow[idx];
      exp_q.push_back(e);
      if (cmd_write) shadow[idx] = cmd_wdata;
      pend = 1'b0;
    end
    if (HREADY) begin
      if (dp_valid && dp_write) slave_mem[dp_idx] = HWDATA;
      dp_valid = (HTRANS == 2'b10);
      dp_idx   = HADDR[5:2];
      dp_write = HWRITE;
    end
    tick();
  endtask

  initial begin
    HRESET = 1'b1;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'd0;
    set_cmd(1'b0, 1'b0, 30'd0, 32'd0);
    tick();
    tick();
    check("reset_htrans", {30'd0, HTRANS}, 32'd0);
    check("reset_haddr", {2'd0, HADDR}, 32'd0);
    check("reset_hwrite", {31'd0, HWRITE}, 32'd0);
    check("reset_hwdata", HWDATA, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    HRESET = 1'b0;

    // Zero-wait read
    set_cmd(1'b1, 1'b0, 30'h4, 32'd0);
    #1;
    check("zw_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    set_cmd(1'b0, 1'b0, 30'h0, 32'd0);
    check("zw_htrans_nonseq", {30'd0, HTRANS}, 32'd2);
    check("zw_haddr", {2'd0, HADDR}, 32'h4);
    check("zw_hwrite", {31'd0, HWRITE}, 32'd0);
    check("zw_busy", {31'd0, busy}, 32'd1);
    tick();
    HRDATA = 32'h0000_0015;
    check("zw_htrans_idle", {30'd0, HTRANS}, 32'd0);
    check("zw_rsp_early", {31'd0, rsp_valid}, 32'd0);
    tick();
    HRDATA = 32'd0;
    check("zw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("zw_rsp_rdata", rsp_rdata, 32'h15);
    check("zw_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("zw_rsp_abort", {31'd0, rsp_abort}, 32'd0);
    tick();
    check("zw_rsp_done", {31'd0, rsp_valid}, 32'd0);
    check("zw_busy_done", {31'd0, busy}, 32'd0);

    // Back-to-back write then read
    set_cmd(1'b1, 1'b1, 30'h0, 32'h1);
    tick();
    set_cmd(1'b1, 1'b0, 30'h4, 32'h0);
    #1;
    check("b2b_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("b2b_wr_haddr", {2'd0, HADDR}, 32'h0);
    check("b2b_wr_hwrite", {31'd0, HWRITE}, 32'd1);
    tick();
    set_cmd(1'b0, 1'b0, 30'h0, 32'd0);
    check("b2b_rd_haddr", {2'd0, HADDR}, 32'h4);
    check("b2b_rd_htrans", {30'd0, HTRANS}, 32'd2);
    check("b2b_hwdata", HWDATA, 32'h1);
    tick();
    HRDATA = 32'h22;
    check("b2b_rsp1_valid", {31'd0, rsp_valid}, 32'd1);
    check("b2b_rsp1_write", {31'd0, rsp_write}, 32'd1);
    check("b2b_rsp1_rdata", rsp_rdata, 32'd0);
    tick();
    HRDATA = 32'd0;
    check("b2b_rsp2_valid", {31'd0, rsp_valid}, 32'd1);
    check("b2b_rsp2_write", {31'd0, rsp_write}, 32'd0);
    check("b2b_rsp2_rdata", rsp_rdata, 32'h22);
    tick();
    check("b2b_rsp_done", {31'd0, rsp_valid}, 32'd0);

    // Read with three wait states in its data phase
    set_cmd(1'b1, 1'b0, 30'h8, 32'h0000_AAAA);
    tick();
    set_cmd(1'b0, 1'b0, 30'h0, 32'd0);
    check("ws_htrans_nonseq", {30'd0, HTRANS}, 32'd2);
    tick();
    for (int i = 0; i < 3; i++) begin
      HREADY = 1'b0;
      HRDATA = 32'hDEAD_0000 + 32'(i);
      #1;
      check("ws_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("ws_htrans", {30'd0, HTRANS}, 32'd0);
      check("ws_haddr", {2'd0, HADDR}, 32'h8);
      check("ws_hwdata", HWDATA, 32'h0000_AAAA);
      check("ws_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    HREADY = 1'b1;
    HRDATA = 32'h33;
    check("ws_rsp_early", {31'd0, rsp_valid}, 32'd0);
    tick();
    HRDATA = 32'd0;
    check("ws_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("ws_rsp_rdata", rsp_rdata, 32'h33);
    tick();

    // Two-cycle ERROR on a write while a read sits in the address phase
    set_cmd(1'b1, 1'b1, 30'hC, 32'h55);
    tick();
    set_cmd(1'b1, 1'b0, 30'h10, 32'd0);
    #1;
    check("err_cmd_ready_rd", {31'd0, cmd_ready}, 32'd1);
    tick();
    set_cmd(1'b0, 1'b0, 30'h0, 32'd0);
    HRESP  = 1'b1;
    HREADY = 1'b0;
    #1;
    check("err_rd_addr_phase", {30'd0, HTRANS}, 32'd2);
    check("err_cmd_ready_first", {31'd0, cmd_ready}, 32'd0);
    tick();
    HREADY = 1'b1;
    check("err_htrans_idle", {30'd0, HTRANS}, 32'd0);
    check("err_busy", {31'd0, busy}, 32'd1);
    tick();
    HRESP = 1'b0;
    #1;
    check("err_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("err_rsp_err", {31'd0, rsp_err}, 32'd1);
    check("err_rsp_abort", {31'd0, rsp_abort}, 32'd0);
    check("err_rsp_write", {31'd0, rsp_write}, 32'd1);
    check("err_cmd_ready_abort", {31'd0, cmd_ready}, 32'd0);
    tick();
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("abort_rsp_abort", {31'd0, rsp_abort}, 32'd1);
    check("abort_rsp_err", {31'd0, rsp_err}, 32'd1);
    check("abort_rsp_write", {31'd0, rsp_write}, 32'd0);
    check("abort_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    check("abort_done", {31'd0, rsp_valid}, 32'd0);
    check("abort_busy_done", {31'd0, busy}, 32'd0);

    // Reset during a data phase
    set_cmd(1'b1, 1'b0, 30'h4, 32'd0);
    tick();
    set_cmd(1'b0, 1'b0, 30'h0, 32'd0);
    tick();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    check("rst_htrans", {30'd0, HTRANS}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("rst_rsp_later", {31'd0, rsp_valid}, 32'd0);

    // Idle bus
    for (int i = 0; i < 10; i++) begin
      check("idle_htrans", {30'd0, HTRANS}, 32'd0);
      check("idle_hsize", {29'd0, HSIZE}, 32'd2);
      check("idle_hburst", {29'd0, HBURST}, 32'd0);
      tick();
    end

    // Random traffic against the memory-backed slave
    for (int i = 0; i < 16; i++) begin
      shadow[i]    = $urandom;
      slave_mem[i] = shadow[i];
    end
    dp_valid = 1'b0;
    dp_idx   = 4'd0;
    dp_write = 1'b0;
    pend     = 1'b0;
    for (int i = 0; i < 400; i++) random_cycle(1'b1);
    for (int i = 0; i < 40 && (pend || exp_q.size() != 0); i++) random_cycle(1'b0);
    check("rnd_drain_pending", {31'd0, pend}, 32'd0);
    check("rnd_drain_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master_bridge.md
Name: ahb_lite_master_bridge

Overview:
- Initiator end of the AHB-Lite bus. Converts a simple valid/ready command stream from local control logic into AHB-Lite single NONSEQ word transfers.
- Drives the bus toward slaves such as the timer slave; the timer slave decodes HADDR[29:0] and honours HSEL and WORK.
- Overlaps the address phase of one transfer with the data phase of the previous one (max 2 outstanding).
- Returns one response per command, carrying read data and error status.

Parameters:
- ADDR_W, 30: HADDR width, matching slave address ports.
- DATA_W, 32: HWDATA/HRDATA width. Transfers are always one full word.

Ports:
- HCLK  in  1  bus clock; the only clock.
- HRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted at a rising edge where cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_write  out  1  echo of the command type.
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborts.
- rsp_err  out  1  slave returned ERROR, or the command was aborted.
- rsp_abort  out  1  command was cancelled before its address phase completed.
- busy  out  1  any transfer outstanding or an abort response pending.
- HADDR  out  ADDR_W  bus address.
- HWRITE  out  1  bus direction.
- HTRANS  out  2  IDLE = 2'b00, NONSEQ = 2'b10 only.
- HSIZE  out  3  constant 3'b010.
- HBURST  out  3  constant 3'b000.
- HWDATA  out  DATA_W  data-phase write data.
- HRDATA  in  DATA_W  read data.
- HREADY  in  1  transfer completion / wait.
- HRESP  in  1  0 = OKAY, 1 = ERROR.

Behaviour:
- All outputs are registered except cmd_ready.
- Reset values:
  - HTRANS = IDLE; HADDR = 0; HWRITE = 0; HWDATA = 0.
  - rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; rsp_abort = 0; rsp_write = 0.
  - busy = 0.
  - Both pipeline stages empty; abort_pend = 0.
- Two stages:
  - A (address phase): a_valid, addr, write, wdata.
  - D (data phase): d_valid, write, wdata.
  - HTRANS = NONSEQ when a_valid, else IDLE.
  - HADDR and HWRITE hold their last value while idle.
  - HWDATA = D.wdata.
- cmd_ready = HREADY && !abort_pend && !first_error_cycle, where first_error_cycle = HRESP && !HREADY.
- Edge with HREADY = 1:
  - D <= A.
  - If D was valid, launch its response (see Responses).
  - A loads the accepted command, or clears if none is accepted.
- Edge with HREADY = 0:
  - A and D hold; no command is accepted.
  - Exception: the error-cancel rule below.
- Latency:
  - Command accepted at edge N: NONSEQ is on the bus in cycle N+1.
  - With zero wait states, data phase is cycle N+2 and rsp_valid is high in cycle N+3.
  - Each slave wait state adds one cycle.
- Back-to-back commands sustain one transfer per cycle with zero wait states.
- Responses:
  - Launched at the edge completing the data phase (d_valid && HREADY).
  - rsp_err = HRESP; rsp_write = D.write.
  - rsp_rdata = HRDATA for reads, 0 for writes.
  - rsp_abort = 0.
- Error-cancel:
  - Applies in the first ERROR cycle (HRESP = 1, HREADY = 0) when a_valid = 1.
  - At that edge a_valid clears, so HTRANS = IDLE in the second ERROR cycle.
  - abort_pend is set, and the cancelled command's write flag is stored.
  - Two cycles later (one cycle after the error response), an abort response is emitted: rsp_err = 1, rsp_abort = 1, rsp_rdata = 0. abort_pend then clears.
  - No new command is accepted while abort_pend = 1.
- Responses are always emitted in command order, never two in the same cycle.
- HRESP = 1 seen with HREADY = 1 on a cycle with no data phase is ignored.
- Reset mid-transfer: all stages drop; HTRANS = IDLE in the next cycle; no response for the dropped commands.
- busy = a_valid || d_valid || abort_pend || rsp_valid.

Test Plan:
- Zero-wait read: after reset, cmd read at addr 0x4, slave returns HRDATA = 0x0000_0015. Required: NONSEQ one cycle after accept; rsp_valid three cycles after accept; rsp_rdata = 0x15; rsp_err = 0.
- Back-to-back: write 0x0 := 0x1, then read 0x4, on consecutive cycles. Required: HWDATA = 0x1 in the cycle the read address is on HADDR; two responses on consecutive cycles, in order.
- Wait states: slave holds HREADY = 0 for 3 cycles in the data phase of a read. Required: HADDR, HTRANS and HWDATA stable; cmd_ready = 0; response 3 cycles later than the zero-wait case.
- Error with pending command: write returns a two-cycle ERROR while a read is in the address phase. Required: HTRANS = IDLE in the second ERROR cycle; error response (rsp_err = 1, rsp_abort = 0); next cycle abort response (rsp_abort = 1, rsp_err = 1).
- Reset mid-operation: assert HRESET while a transfer is in its data phase. Required: next cycle HTRANS = IDLE, busy = 0, no rsp_valid.
- Idle bus: no commands for 10 cycles. Required: HTRANS stays IDLE; HSIZE = 3'b010 and HBURST = 3'b000 throughout.
